// File: rtl/pkt_validator.sv
// Store-and-forward packet validator.
// Accepts header + N payload words + XOR checksum word from the packet buffer.
// Drops packets with a bad magic, a bad length or a bad checksum, and counts
// each kind of drop. Forwards good packets (header then payload) tagged with
// a 2-bit class taken from header[17:16].
//
// Handshake: a word moves on any rising edge where valid && ready, on both the
// input side (in_valid/in_ready) and the output side (out_valid/out_ready).
// out_data/out_last/out_class are held while out_valid && !out_ready.
// The FSM state is the internal signal `state` (IDLE/PAYLOAD/CHECK/SEND).
module pkt_validator #(
  parameter int         MAX_LEN = 15,
  parameter logic [7:0] MAGIC   = 8'hA5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic [1:0]  out_class,
  output logic [15:0] cnt_ok,
  output logic [7:0]  cnt_err_magic,
  output logic [7:0]  cnt_err_len,
  output logic [7:0]  cnt_err_csum
);

  // Counter width for 0..MAX_LEN and address width for the payload buffer.
  localparam int         IW       = $clog2(MAX_LEN + 1);
  localparam int         AW       = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [7:0] MAX_LEN8 = 8'(MAX_LEN);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAYLOAD = 2'd1,
    CHECK   = 2'd2,
    SEND    = 2'd3
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic          alive;      // low during reset and until the first edge after it
  logic [31:0]   hdr;
  logic [31:0]   csum;
  logic [IW-1:0] len;
  logic [IW-1:0] idx;
  logic [IW-1:0] rd;         // 0 = header, k = payload word k-1
  logic [IW-1:0] rd_m1;
  logic [31:0]   mem [0:MAX_LEN-1];

  logic in_fire;
  logic out_fire;
  logic magic_bad;
  logic len_bad;
  logic inc_ok;
  logic inc_magic;
  logic inc_len;
  logic inc_csum;

  // Handshake, header classification and the output word mux.
  always_comb begin
    in_ready  = alive && (state != SEND);
    out_valid = (state == SEND);
    in_fire   = in_valid && in_ready;
    out_fire  = out_valid && out_ready;
    magic_bad = (in_data[31:24] != MAGIC);
    len_bad   = (in_data[15:8] == 8'd0) || (in_data[15:8] > MAX_LEN8);
    rd_m1     = rd - IW'(1);
    out_data  = 32'd0;
    out_last  = 1'b0;
    out_class = 2'd0;
    if (state == SEND) begin
      out_data  = (rd == '0) ? hdr : mem[rd_m1[AW-1:0]];
      out_last  = (rd == len);
      out_class = hdr[17:16];
    end
  end

  // Next-state logic and one-cycle counter increment requests.
  always_comb begin
    state_nx  = state;
    inc_ok    = 1'b0;
    inc_magic = 1'b0;
    inc_len   = 1'b0;
    inc_csum  = 1'b0;
    case (state)
      IDLE: begin
        if (in_fire) begin
          if (magic_bad)    inc_magic = 1'b1;
          else if (len_bad) inc_len   = 1'b1;
          else              state_nx  = PAYLOAD;
        end
      end
      PAYLOAD: begin
        if (in_fire && (idx == len - IW'(1))) state_nx = CHECK;
      end
      CHECK: begin
        if (in_fire) begin
          if (in_data == csum) begin
            state_nx = SEND;
          end else begin
            inc_csum = 1'b1;
            state_nx = IDLE;
          end
        end
      end
      SEND: begin
        if (out_fire && (rd == len)) begin
          inc_ok   = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State register, header/checksum/index datapath and saturating counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      alive         <= 1'b0;
      hdr           <= 32'd0;
      csum          <= 32'd0;
      len           <= '0;
      idx           <= '0;
      rd            <= '0;
      cnt_ok        <= 16'd0;
      cnt_err_magic <= 8'd0;
      cnt_err_len   <= 8'd0;
      cnt_err_csum  <= 8'd0;
    end else begin
      alive <= 1'b1;
      state <= state_nx;
      case (state)
        IDLE: begin
          if (in_fire && !magic_bad && !len_bad) begin
            hdr  <= in_data;
            len  <= in_data[8 +: IW];
            csum <= in_data;
            idx  <= '0;
          end
        end
        PAYLOAD: begin
          if (in_fire) begin
            csum <= csum ^ in_data;
            idx  <= idx + IW'(1);
          end
        end
        CHECK: begin
          if (in_fire) rd <= '0;
        end
        SEND: begin
          if (out_fire) rd <= rd + IW'(1);
        end
        default: ;
      endcase
      if (inc_ok    && (cnt_ok        != '1)) cnt_ok        <= cnt_ok + 16'd1;
      if (inc_magic && (cnt_err_magic != '1)) cnt_err_magic <= cnt_err_magic + 8'd1;
      if (inc_len   && (cnt_err_len   != '1)) cnt_err_len   <= cnt_err_len + 8'd1;
      if (inc_csum  && (cnt_err_csum  != '1)) cnt_err_csum  <= cnt_err_csum + 8'd1;
    end
  end

  // Payload buffer; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if ((state == PAYLOAD) && in_fire) mem[idx[AW-1:0]] <= in_data;
  end

endmodule

// File: tb/tb_pkt_validator.sv
// Testbench for pkt_validator: directed test-plan packets plus random packets,
// checked against a packet-level reference model and an expected-output queue.
module tb_pkt_validator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] in_data = 32'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        out_last;
  logic [1:0]  out_class;
  logic [15:0] cnt_ok;
  logic [7:0]  cnt_err_magic;
  logic [7:0]  cnt_err_len;
  logic [7:0]  cnt_err_csum;

  pkt_validator #(.MAX_LEN(15), .MAGIC(8'hA5)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .out_class(out_class),
    .cnt_ok(cnt_ok), .cnt_err_magic(cnt_err_magic),
    .cnt_err_len(cnt_err_len), .cnt_err_csum(cnt_err_csum)
  );

  // clock
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // expected output words: {class[1:0], last, data[31:0]}
  logic [34:0] exp_q[$];
  logic [31:0] pkt_q[$];
  int m_ok = 0, m_magic = 0, m_len = 0, m_csum = 0;
  bit rand_rdy = 1'b0;
  bit gap_en = 1'b0;
  int n_out = 0;
  bit stall_prev = 1'b0;
  logic [34:0] prev_o;
  logic [34:0] mon_e;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int v, input int mx);
    return (v >= mx) ? mx : v + 1;
  endfunction

  // out_ready driver: constant 1 or random backpressure
  always begin
    @(posedge clk);
    #1;
    out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // output monitor / scoreboard
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_word", {out_class, out_last, out_data}, prev_o);
      end
      if (out_valid) chk("in_ready_in_send", in_ready, 0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out", out_data, 64'hDEAD_0000_0000);
        end else begin
          mon_e = exp_q.pop_front();
          chk("out_data", out_data, mon_e[31:0]);
          chk("out_last", out_last, mon_e[32]);
          chk("out_class", out_class, mon_e[34:33]);
        end
        n_out++;
      end
      stall_prev = out_valid && !out_ready;
      prev_o = {out_class, out_last, out_data};
    end
  end

  // drive one input word and wait (bounded) until it is accepted
  task automatic send_word(input logic [31:0] w);
    bit done;
    if (gap_en) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    in_valid = 1'b1;
    in_data  = w;
    done = 1'b0;
    for (int t = 0; t < 300 && !done; t++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        done = 1'b1;
      end
    end
    in_valid = 1'b0;
    if (!done) chk("in_ready_timeout", 0, 1);
  endtask

  // packet-level model, then send pkt_q
  task automatic send_pkt();
    logic [31:0] h, x;
    int n;
    bit good, csum_bad;
    h = pkt_q[0];
    n = int'(h[15:8]);
    good = 1'b0;
    csum_bad = 1'b0;
    if (h[31:24] != 8'hA5) begin
      m_magic = sat(m_magic, 255);
    end else if (n == 0 || n > 15) begin
      m_len = sat(m_len, 255);
    end else begin
      x = 32'd0;
      for (int i = 0; i <= n; i++) x ^= pkt_q[i];
      if (x == pkt_q[n+1]) begin
        good = 1'b1;
        for (int i = 0; i <= n; i++) exp_q.push_back({h[17:16], (i == n), pkt_q[i]});
        m_ok = sat(m_ok, 65535);
      end else begin
        csum_bad = 1'b1;
        m_csum = sat(m_csum, 255);
      end
    end
    foreach (pkt_q[i]) send_word(pkt_q[i]);
    if (good) begin
      @(negedge clk);
      chk("first_out_latency", out_valid, 1);
      @(posedge clk); #1;
    end else if (csum_bad) begin
      @(negedge clk);
      chk("csum_drop_no_out", out_valid, 0);
      chk("csum_drop_in_ready", in_ready, 1);
      @(posedge clk); #1;
    end
  endtask

  // build a packet; non-framed headers get no payload/checksum
  task automatic mk_pkt(input logic [7:0] mg, input int n, input bit corrupt);
    logic [31:0] h, w, x;
    pkt_q.delete();
    h = {mg, 8'($urandom), 8'(n), 8'($urandom)};
    pkt_q.push_back(h);
    if (mg == 8'hA5 && n >= 1 && n <= 15) begin
      x = h;
      for (int i = 0; i < n; i++) begin
        w = $urandom;
        if ($urandom_range(0, 3) == 0) w[31:24] = 8'hA5;
        pkt_q.push_back(w);
        x ^= w;
      end
      pkt_q.push_back(corrupt ? (x ^ (32'd1 << $urandom_range(0, 31))) : x);
    end
  endtask

  task automatic check_counters(input string tag);
    bit drained;
    drained = 1'b0;
    for (int t = 0; t < 500 && !drained; t++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !out_valid) drained = 1'b1;
    end
    if (!drained) chk({tag, "_drain_timeout"}, 0, 1);
    chk({tag, "_cnt_ok"}, cnt_ok, m_ok);
    chk({tag, "_cnt_magic"}, cnt_err_magic, m_magic);
    chk({tag, "_cnt_len"}, cnt_err_len, m_len);
    chk({tag, "_cnt_csum"}, cnt_err_csum, m_csum);
    @(posedge clk); #1;
  endtask

  initial begin
    int k, base;
    logic [7:0] mg;
    bit reached;

    // reset state
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_class", out_class, 0);
    chk("rst_counters", {cnt_ok, cnt_err_magic, cnt_err_len, cnt_err_csum}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);
    @(posedge clk); #1;

    // good packet
    pkt_q = '{32'hA5010207, 32'h11111111, 32'h22222222, 32'h96323134};
    send_pkt();
    check_counters("good");
    chk("good_cnt_ok_one", cnt_ok, 1);

    // bad checksum then good packet
    pkt_q = '{32'hA5010207, 32'h11111111, 32'h22222222, 32'h96323135};
    send_pkt();
    pkt_q = '{32'hA5010207, 32'h11111111, 32'h22222222, 32'h96323134};
    send_pkt();
    check_counters("csum");
    chk("csum_cnt_one", cnt_err_csum, 1);

    // framing errors then good packet
    pkt_q = '{32'h5A010207}; send_pkt();
    pkt_q = '{32'hA5000007}; send_pkt();
    pkt_q = '{32'hA5001007}; send_pkt();
    mk_pkt(8'hA5, 3, 1'b0); send_pkt();
    check_counters("framing");
    chk("framing_len_two", cnt_err_len, 2);

    // backpressure, N = MAX_LEN
    rand_rdy = 1'b1;
    mk_pkt(8'hA5, 15, 1'b0); send_pkt();
    check_counters("bp");

    // random mix
    gap_en = 1'b1;
    for (int p = 0; p < 30; p++) begin
      k = $urandom_range(0, 9);
      case (k)
        0: begin
          mg = 8'($urandom_range(0, 255));
          if (mg == 8'hA5) mg = 8'h5A;
          mk_pkt(mg, $urandom_range(0, 255), 1'b0);
        end
        1: mk_pkt(8'hA5, ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(16, 255), 1'b0);
        2: mk_pkt(8'hA5, $urandom_range(1, 15), 1'b1);
        default: mk_pkt(8'hA5, $urandom_range(1, 15), 1'b0);
      endcase
      send_pkt();
    end
    check_counters("random");

    // reset in the middle of SEND
    rand_rdy = 1'b0;
    gap_en = 1'b0;
    @(posedge clk); #1;
    base = n_out;
    mk_pkt(8'hA5, 6, 1'b0);
    send_pkt();
    reached = 1'b0;
    for (int t = 0; t < 50 && !reached; t++) begin
      @(negedge clk);
      if (n_out >= base + 2) reached = 1'b1;
    end
    if (!reached) chk("midsend_wait_timeout", 0, 1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    exp_q.delete();
    m_ok = 0; m_magic = 0; m_len = 0; m_csum = 0;
    #1;
    chk("midsend_out_valid", out_valid, 0);
    chk("midsend_in_ready", in_ready, 0);
    chk("midsend_counters", {cnt_ok, cnt_err_magic, cnt_err_len, cnt_err_csum}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midsend_rel_in_ready", in_ready, 1);
    @(posedge clk); #1;
    mk_pkt(8'hA5, 4, 1'b0); send_pkt();
    check_counters("after_rst");

    // saturation of the magic counter
    for (int p = 0; p < 260; p++) begin
      mg = 8'($urandom_range(0, 255));
      if (mg == 8'hA5) mg = 8'h00;
      mk_pkt(mg, $urandom_range(0, 255), 1'b0);
      send_pkt();
    end
    check_counters("sat");
    chk("sat_magic_255", cnt_err_magic, 255);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
